// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the mul/div sequencer: opcode and ALU-op values, state encoding, and
// the default exception and timeout parameters.
package multdiv_sequencer_pkg;

    localparam logic [4:0] R_OP   = 5'b00000;
    localparam logic [4:0] MUL_OP = 5'b00110;
    localparam logic [4:0] DIV_OP = 5'b00111;

    localparam int unsigned RSTATUS_IDX = 30;
    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned DEF_MUL_CODE = 4;
    localparam int unsigned DEF_DIV_CODE = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StBusy  = 2'd2,
        StDone  = 2'd3
    } md_state_e;

endpackage

// File: rtl/multdiv_sequencer_decode.sv
// Combinational decode of a DX instruction into mul/div flags and destination register.
// Kept separate so hazard/stall logic can reuse the same decode.
module multdiv_sequencer_decode
    import multdiv_sequencer_pkg::*;
(
    input  logic [31:0] insn,
    output logic        is_mul,
    output logic        is_div,
    output logic [4:0]  rd
);

    logic r_type;

    always_comb begin
        r_type = (insn[31:27] == R_OP);
        is_mul = r_type && (insn[6:2] == MUL_OP);
        is_div = r_type && (insn[6:2] == DIV_OP);
        rd     = insn[26:22];
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared multi-cycle multiplier/divider: accepts a mul/div from DX, pulses the unit,
// stalls the front end while busy, then presents the result or an exception code for writeback.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned MUL_CODE = DEF_MUL_CODE,
    parameter int unsigned DIV_CODE = DEF_DIV_CODE,
    parameter int unsigned RSTATUS  = RSTATUS_IDX
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dx_valid,
    input  logic [31:0] dx_insn,
    input  logic [31:0] dx_opA,
    input  logic [31:0] dx_opB,
    input  logic        multdiv_RDY,
    input  logic        multdiv_exception,
    input  logic [31:0] multdiv_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ack
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            op_div_q, op_div_d;
    logic [4:0]      rd_q, rd_d;
    logic            ctrl_mult_d, ctrl_div_d;
    logic [31:0]     md_opa_d, md_opb_d;
    logic            wb_valid_d;
    logic [4:0]      wb_rd_d;
    logic [31:0]     wb_data_d;

    logic            dec_mul, dec_div;
    logic [4:0]      dec_rd;

    multdiv_sequencer_decode u_decode (
        .insn   (dx_insn),
        .is_mul (dec_mul),
        .is_div (dec_div),
        .rd     (dec_rd)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_div_d    = op_div_q;
        rd_d        = rd_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        md_opa_d    = md_opA;
        md_opb_d    = md_opB;
        wb_valid_d  = wb_valid;
        wb_rd_d     = wb_rd;
        wb_data_d   = wb_data;

        unique case (state_q)
            StIdle: begin
                if (dx_valid && (dec_mul || dec_div)) begin
                    md_opa_d    = dx_opA;
                    md_opb_d    = dx_opB;
                    rd_d        = dec_rd;
                    op_div_d    = dec_div;
                    ctrl_mult_d = dec_mul;
                    ctrl_div_d  = dec_div;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A real result wins over a timeout landing on the same cycle.
                if (multdiv_RDY && !multdiv_exception) begin
                    if (rd_q == 5'd0) begin
                        state_d = StIdle;
                    end else begin
                        wb_rd_d    = rd_q;
                        wb_data_d  = multdiv_result;
                        wb_valid_d = 1'b1;
                        state_d    = StDone;
                    end
                end else if (multdiv_RDY || (cnt_q == CntMax)) begin
                    wb_rd_d    = 5'(RSTATUS);
                    wb_data_d  = op_div_q ? 32'(DIV_CODE) : 32'(MUL_CODE);
                    wb_valid_d = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (wb_ack) begin
                    wb_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            rd_q      <= 5'd0;
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            md_opA    <= 32'd0;
            md_opB    <= 32'd0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            rd_q      <= rd_d;
            ctrl_MULT <= ctrl_mult_d;
            ctrl_DIV  <= ctrl_div_d;
            md_opA    <= md_opa_d;
            md_opB    <= md_opb_d;
            wb_valid  <= wb_valid_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
        end
    end

    assign stall = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: table of single transactions plus hand-written
// sequences for timeout, mid-operation reset and back-to-back issue.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        dx_valid;
    logic [31:0] dx_insn, dx_opA, dx_opB;
    logic        multdiv_RDY, multdiv_exception;
    logic [31:0] multdiv_result;
    logic        ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_ack;
    logic [31:0] md_opA, md_opB, wb_data;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_sequencer dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .dx_valid          (dx_valid),
        .dx_insn           (dx_insn),
        .dx_opA            (dx_opA),
        .dx_opB            (dx_opB),
        .multdiv_RDY       (multdiv_RDY),
        .multdiv_exception (multdiv_exception),
        .multdiv_result    (multdiv_result),
        .ctrl_MULT         (ctrl_MULT),
        .ctrl_DIV          (ctrl_DIV),
        .md_opA            (md_opA),
        .md_opB            (md_opB),
        .stall             (stall),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .wb_ack            (wb_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
        bit          stale;
        bit          exc;
        logic [31:0] result;
        bit          acc;
        bit          exp_mul;
        bit          exp_div;
        bit          exp_valid;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] mk_insn(input logic [4:0] opc, input logic [4:0] rd,
                                            input logic [4:0] aluop);
        return {opc, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl_MULT"}, 32'(ctrl_MULT), 32'd0);
        check({tag, " ctrl_DIV"}, 32'(ctrl_DIV), 32'd0);
        check({tag, " stall"}, 32'(stall), 32'd0);
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
        check({tag, " wb_data"}, wb_data, 32'd0);
        check({tag, " md_opA"}, md_opA, 32'd0);
        check({tag, " md_opB"}, md_opB, 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        string t;
        v = vecs[idx];
        t = $sformatf("vec%0d", idx);
        dx_valid = 1'b1;
        dx_insn  = v.insn;
        dx_opA   = v.a;
        dx_opB   = v.b;
        check({t, " idle stall"}, 32'(stall), 32'd0);
        tick();
        dx_valid = 1'b0;
        if (!v.acc) begin
            check({t, " not accepted stall"}, 32'(stall), 32'd0);
            check({t, " no pulse"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
            return;
        end
        check({t, " issue ctrl_MULT"}, 32'(ctrl_MULT), 32'(v.exp_mul));
        check({t, " issue ctrl_DIV"}, 32'(ctrl_DIV), 32'(v.exp_div));
        check({t, " issue stall"}, 32'(stall), 32'd1);
        check({t, " md_opA"}, md_opA, v.a);
        check({t, " md_opB"}, md_opB, v.b);
        if (v.stale) begin
            multdiv_RDY    = 1'b1;
            multdiv_result = 32'hdead_beef;
        end
        tick();
        multdiv_RDY = 1'b0;
        check({t, " busy pulse gone"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        check({t, " busy stall"}, 32'(stall), 32'd1);
        check({t, " busy wb_valid"}, 32'(wb_valid), 32'd0);
        for (int i = 1; i < v.delay; i++) tick();
        multdiv_RDY       = 1'b1;
        multdiv_exception = v.exc;
        multdiv_result    = v.result;
        tick();
        multdiv_RDY       = 1'b0;
        multdiv_exception = 1'b0;
        multdiv_result    = 32'h0;
        check({t, " wb_valid"}, 32'(wb_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check({t, " wb_rd"}, 32'(wb_rd), 32'(v.exp_rd));
            check({t, " wb_data"}, wb_data, v.exp_data);
            check({t, " done stall"}, 32'(stall), 32'd1);
            tick();
            check({t, " wb_data hold"}, wb_data, v.exp_data);
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
            check({t, " post-ack wb_valid"}, 32'(wb_valid), 32'd0);
        end
        check({t, " back to idle stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        int cycles;
        bit seen;

        vecs[0] = '{mk_insn(5'd0, 5'd3, 5'b00110), 32'd6, 32'd7, 5, 1'b0, 1'b0, 32'd42,
                    1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'd42};
        vecs[1] = '{mk_insn(5'd0, 5'd4, 5'b00111), 32'd9, 32'd0, 3, 1'b0, 1'b1, 32'd0,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd30, 32'd5};
        vecs[2] = '{mk_insn(5'd0, 5'd0, 5'b00110), 32'd11, 32'd9, 2, 1'b0, 1'b0, 32'd99,
                    1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[3] = '{mk_insn(5'd0, 5'd31, 5'b00111), 32'd100, 32'd7, 1, 1'b1, 1'b0, 32'd14,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'd14};
        vecs[4] = '{mk_insn(5'd0, 5'd0, 5'b00110), 32'h8000_0000, 32'd2, 4, 1'b0, 1'b1, 32'd0,
                    1'b1, 1'b1, 1'b0, 1'b1, 5'd30, 32'd4};
        vecs[5] = '{mk_insn(5'd1, 5'd5, 5'b00110), 32'd1, 32'd2, 1, 1'b0, 1'b0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[6] = '{mk_insn(5'd0, 5'd5, 5'b00000), 32'd1, 32'd2, 1, 1'b0, 1'b0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};

        reset_n = 1'b0; dx_valid = 1'b0; dx_insn = '0; dx_opA = '0; dx_opB = '0;
        multdiv_RDY = 1'b0; multdiv_exception = 1'b0; multdiv_result = '0; wb_ack = 1'b0;
        #12;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Timeout: no RDY ever arrives for a mul.
        dx_valid = 1'b1; dx_insn = mk_insn(5'd0, 5'd7, 5'b00110); dx_opA = 32'd3; dx_opB = 32'd3;
        tick();
        dx_valid = 1'b0;
        cycles = 0;
        while (!wb_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        check("timeout latency", 32'(cycles), 32'd66);
        check("timeout wb_rd", 32'(wb_rd), 32'd30);
        check("timeout wb_data", wb_data, 32'd4);
        check("timeout stall in done", 32'(stall), 32'd1);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("timeout stall after ack", 32'(stall), 32'd0);

        // Reset while busy, then a late RDY must be ignored.
        dx_valid = 1'b1; dx_insn = mk_insn(5'd0, 5'd5, 5'b00110); dx_opA = 32'd4; dx_opB = 32'd5;
        tick();
        dx_valid = 1'b0;
        tick();
        tick();
        check("pre-reset stall", 32'(stall), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid-busy reset");
        #2;
        reset_n = 1'b1;
        tick();
        multdiv_RDY = 1'b1; multdiv_result = 32'd20;
        tick();
        multdiv_RDY = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= wb_valid | stall;
            tick();
        end
        check("post-reset no activity", 32'(seen), 32'd0);

        // Back-to-back muls, second one held in DX by stall.
        dx_valid = 1'b1; dx_insn = mk_insn(5'd0, 5'd8, 5'b00110); dx_opA = 32'd2; dx_opB = 32'd3;
        tick();
        dx_insn = mk_insn(5'd0, 5'd9, 5'b00110); dx_opA = 32'd10; dx_opB = 32'd11;
        check("b2b first pulse", 32'(ctrl_MULT), 32'd1);
        tick();
        tick();
        multdiv_RDY = 1'b1; multdiv_result = 32'd6;
        tick();
        multdiv_RDY = 1'b0; multdiv_result = 32'hffff_ffff;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("b2b wb_valid held", 32'(wb_valid), 32'd1);
            check("b2b wb_data held", wb_data, 32'd6);
            seen |= ctrl_MULT | ~stall;
            tick();
        end
        check("b2b no early issue", 32'(seen), 32'd0);
        check("b2b wb_rd", 32'(wb_rd), 32'd8);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("b2b idle after ack", 32'(stall), 32'd0);
        check("b2b wb_valid dropped", 32'(wb_valid), 32'd0);
        tick();
        dx_valid = 1'b0;
        check("b2b second pulse", 32'(ctrl_MULT), 32'd1);
        check("b2b second opA", md_opA, 32'd10);
        check("b2b second opB", md_opB, 32'd11);
        tick();
        multdiv_RDY = 1'b1; multdiv_result = 32'd110;
        tick();
        multdiv_RDY = 1'b0;
        check("b2b second wb_rd", 32'(wb_rd), 32'd9);
        check("b2b second wb_data", wb_data, 32'd110);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("b2b final idle", 32'(stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
